// File: rtl/wait_sched_pkg.sv
// Shared types for the wait scheduler: per-slot state, slot record and pointer-width helper.
// Slot fields use the package widths; the top's CNT_W/STATE_W must not exceed them.
package wait_sched_pkg;

  localparam int WS_CNT_W   = 32;
  localparam int WS_STATE_W = 32;

  typedef enum logic {
    SLOT_IDLE    = 1'b0,
    SLOT_WAITING = 1'b1
  } slot_state_e;

  typedef struct packed {
    slot_state_e              state;
    logic [WS_CNT_W-1:0]      cnt;
    logic [WS_STATE_W-1:0]    resume;
  } slot_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wait_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first eligible requester at or after ptr, one-hot grant.
module wait_sched_rr_arbiter #(
  parameter int NUM_THREADS = 4,
  parameter int PTR_W       = 2
) (
  input  logic [NUM_THREADS-1:0] eligible,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_THREADS-1:0] grant
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NUM_THREADS; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NUM_THREADS);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wait_scheduler.sv
// Central wait-timer scheduler: threads post wait(n) with a resume state, one accept per cycle.
// Optional feature: define WAIT_SCHED_STATS_EN to add the saturating stall_cycles counter.
module wait_scheduler
  import wait_sched_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int CNT_W       = WS_CNT_W,
  parameter int STATE_W     = WS_STATE_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         req_valid,
  input  logic [NUM_THREADS*CNT_W-1:0]   req_count,
  input  logic [NUM_THREADS*STATE_W-1:0] req_state,
  output logic [NUM_THREADS-1:0]         req_ready,
  input  logic [NUM_THREADS-1:0]         cancel,
  output logic [NUM_THREADS-1:0]         resume_valid,
  output logic [NUM_THREADS*STATE_W-1:0] resume_state,
  output logic [NUM_THREADS-1:0]         busy
`ifdef WAIT_SCHED_STATS_EN
  ,
  output logic [31:0]                    stall_cycles
`endif
);

  localparam int PTR_W = ptr_w(NUM_THREADS);

  slot_t                          slot_q [NUM_THREADS];
  slot_t                          slot_d [NUM_THREADS];
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [NUM_THREADS-1:0]         resume_valid_q, resume_valid_d;
  logic [NUM_THREADS*STATE_W-1:0] resume_state_q, resume_state_d;
  logic [NUM_THREADS-1:0]         idle, eligible, grant;

  always_comb begin
    for (int i = 0; i < NUM_THREADS; i++) begin
      idle[i]     = (slot_q[i].state == SLOT_IDLE);
      eligible[i] = req_valid[i] && idle[i] && !cancel[i];
      busy[i]     = !idle[i];
    end
  end

  wait_sched_rr_arbiter #(
    .NUM_THREADS (NUM_THREADS),
    .PTR_W       (PTR_W)
  ) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant)
  );

  assign req_ready    = grant;
  assign resume_valid = resume_valid_q;
  assign resume_state = resume_state_q;

  always_comb begin
    ptr_d = ptr_q;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant[i]) ptr_d = (i == NUM_THREADS - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // Slot update: cancel beats expiry; wait(0) is loaded as a one-cycle wait.
  always_comb begin
    resume_valid_d = '0;
    resume_state_d = resume_state_q;
    for (int i = 0; i < NUM_THREADS; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i].state)
        SLOT_IDLE: begin
          if (grant[i]) begin
            slot_d[i].state  = SLOT_WAITING;
            slot_d[i].cnt    = (req_count[i*CNT_W +: CNT_W] == '0) ? WS_CNT_W'(1)
                                 : WS_CNT_W'(req_count[i*CNT_W +: CNT_W]);
            slot_d[i].resume = WS_STATE_W'(req_state[i*STATE_W +: STATE_W]);
          end
        end
        SLOT_WAITING: begin
          if (cancel[i]) begin
            slot_d[i].state = SLOT_IDLE;
          end else if (slot_q[i].cnt == WS_CNT_W'(1)) begin
            slot_d[i].state                     = SLOT_IDLE;
            resume_valid_d[i]                   = 1'b1;
            resume_state_d[i*STATE_W +: STATE_W] = STATE_W'(slot_q[i].resume);
          end else begin
            slot_d[i].cnt = slot_q[i].cnt - WS_CNT_W'(1);
          end
        end
        default: slot_d[i].state = SLOT_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        slot_q[i] <= '{state: SLOT_IDLE, cnt: '0, resume: '0};
      end
      ptr_q          <= '0;
      resume_valid_q <= '0;
      resume_state_q <= '0;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        slot_q[i] <= slot_d[i];
      end
      ptr_q          <= ptr_d;
      resume_valid_q <= resume_valid_d;
      resume_state_q <= resume_state_d;
    end
  end

`ifdef WAIT_SCHED_STATS_EN
  logic [31:0] stall_q, stall_d, stall_inc;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // Each idle requester left waiting by the arbiter adds one stall cycle.
  always_comb begin
    stall_inc = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      stall_inc = stall_inc + 32'(req_valid[i] & idle[i] & ~grant[i]);
    end
    stall_d = sat_add32(stall_q, stall_inc);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wait_scheduler.sv
// Directed bench for wait_scheduler; define WAIT_SCHED_STATS_EN to also exercise stall_cycles.
module tb_wait_scheduler;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_count;
  logic [127:0] req_state;
  logic [3:0]   req_ready;
  logic [3:0]   cancel;
  logic [3:0]   resume_valid;
  logic [127:0] resume_state;
  logic [3:0]   busy;
`ifdef WAIT_SCHED_STATS_EN
  logic [31:0]  stall_cycles;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  logic [3:0]  exp_rv   [6] = '{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [3:0]  exp_busy [6] = '{4'b0001, 4'b0011, 4'b0110, 4'b1100, 4'b1000, 4'b0000};
  logic [31:0] exp_stall[4] = '{32'd3, 32'd5, 32'd6, 32'd6};

  wait_scheduler #(
    .NUM_THREADS (4),
    .CNT_W       (32),
    .STATE_W     (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_count    (req_count),
    .req_state    (req_state),
    .req_ready    (req_ready),
    .cancel       (cancel),
    .resume_valid (resume_valid),
    .resume_state (resume_state),
    .busy         (busy)
`ifdef WAIT_SCHED_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] n, input logic [31:0] st);
    req_valid[i]          = 1'b1;
    req_count[i*32 +: 32] = n;
    req_state[i*32 +: 32] = st;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check({tag, "_rv"},   resume_valid, 4'b0000);
    check({tag, "_busy"}, busy,         4'b0000);
    check({tag, "_rs"},   resume_state, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_count = '0;
    req_state = '0;
    cancel    = '0;
    do_reset("rst0");

    // single wait(4)
    set_req(0, 32'd4, 32'd7);
    #1;
    check("t1_rdy", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("t1_busy_e0", busy, 4'b0001);
    check("t1_rv_e0", resume_valid, 4'b0000);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("t1_busy_wait", busy, 4'b0001);
      check("t1_rv_wait", resume_valid, 4'b0000);
    end
    tick();
    check("t1_rv_pulse", resume_valid, 4'b0001);
    check("t1_rs_pulse", resume_state, 128'h7);
    check("t1_busy_done", busy, 4'b0000);
    tick();
    check("t1_rv_after", resume_valid, 4'b0000);
    check("t1_rs_hold", resume_state, 128'h7);

    do_reset("rst1");

    // four-way contention, count=2
    for (int i = 0; i < 4; i++) set_req(i, 32'd2, 32'h10 + 32'(i));
    #1;
    for (int j = 0; j < 6; j++) begin
      if (j < 4) check("t2_rdy", req_ready, 4'b0001 << j);
      tick();
      if (j < 4) req_valid[j] = 1'b0;
      check("t2_rv", resume_valid, exp_rv[j]);
      check("t2_busy", busy, exp_busy[j]);
      #1;
    end
    check("t2_rs", resume_state, 128'h00000013_00000012_00000011_00000010);

    // wait(0) behaves as wait(1); pointer back at 0; re-grant during resume cycle
    set_req(0, 32'd0, 32'h21);
    set_req(3, 32'd0, 32'h23);
    #1;
    check("t3_rdy0", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("t3_busy_e0", busy, 4'b0001);
    check("t3_rv_e0", resume_valid, 4'b0000);
    #1;
    check("t3_rdy3", req_ready, 4'b1000);
    tick();
    check("t3_rv_e1", resume_valid, 4'b0001);
    check("t3_busy_e1", busy, 4'b1000);
    check("t3_rs_e1", resume_state, 128'h00000013_00000012_00000011_00000021);
    req_valid[3] = 1'b0;
    set_req(0, 32'd1, 32'h31);
    #1;
    check("t3_regrant", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    check("t3_rv_e2", resume_valid, 4'b1000);
    check("t3_busy_e2", busy, 4'b0001);
    check("t3_rs_e2", resume_state, 128'h00000023_00000012_00000011_00000021);
    tick();
    check("t3_rv_e3", resume_valid, 4'b0001);
    check("t3_busy_e3", busy, 4'b0000);
    check("t3_rs_e3", resume_state, 128'h00000023_00000012_00000011_00000031);

    // cancel a waiting slot, then cancel on an idle slot blocks grant
    set_req(2, 32'd5, 32'h44);
    #1;
    check("t4_rdy", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    check("t4_busy_e0", busy, 4'b0100);
    tick();
    tick();
    check("t4_busy_e2", busy, 4'b0100);
    cancel[2] = 1'b1;
    tick();
    cancel[2] = 1'b0;
    check("t4_busy_cancel", busy, 4'b0000);
    check("t4_rv_cancel", resume_valid, 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t4_rv_none", resume_valid, 4'b0000);
    end
    set_req(2, 32'd1, 32'h55);
    cancel[2] = 1'b1;
    #1;
    check("t4_cancel_idle", req_ready, 4'b0000);
    cancel[2] = 1'b0;
    #1;
    check("t4_rdy_new", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    check("t4_busy_new", busy, 4'b0100);
    tick();
    check("t4_rv_new", resume_valid, 4'b0100);
    check("t4_rs_new", resume_state, 128'h00000023_00000055_00000011_00000031);

    // cancel on the expiry edge wins
    set_req(1, 32'd2, 32'h66);
    #1;
    check("t5_rdy", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    check("t5_busy_e0", busy, 4'b0010);
    tick();
    check("t5_busy_e1", busy, 4'b0010);
    cancel[1] = 1'b1;
    tick();
    cancel[1] = 1'b0;
    check("t5_rv_race", resume_valid, 4'b0000);
    check("t5_busy_race", busy, 4'b0000);
    check("t5_rs_hold", resume_state, 128'h00000023_00000055_00000011_00000031);
    tick();
    check("t5_rv_after", resume_valid, 4'b0000);

    // reset in the middle of a wait
    set_req(0, 32'd3, 32'h77);
    #1;
    tick();
    req_valid[0] = 1'b0;
    check("t5_busy_pre", busy, 4'b0001);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_rv", resume_valid, 4'b0000);
    check("t5_rst_busy", busy, 4'b0000);
    check("t5_rst_rs", resume_state, 128'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t5_post_rv", resume_valid, 4'b0000);
      check("t5_post_busy", busy, 4'b0000);
    end

`ifdef WAIT_SCHED_STATS_EN
    // stall accounting with four held requests
    check("t6_stall0", stall_cycles, 32'd0);
    for (int i = 0; i < 4; i++) set_req(i, 32'd8, 32'h80 + 32'(i));
    #1;
    for (int j = 0; j < 4; j++) begin
      check("t6_rdy", req_ready, 4'b0001 << j);
      tick();
      req_valid[j] = 1'b0;
      check("t6_stall", stall_cycles, exp_stall[j]);
      #1;
    end
    tick();
    check("t6_stall_hold", stall_cycles, 32'd6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
